// File: rtl/upper_ram_arbiter_if.sv
// AdamNet DMA request/response bundle for the shared upper-RAM arbiter.
// The DMA requester drives the request side (master); the arbiter answers (slave).
interface upper_ram_arbiter_if;
  logic [15:0] ramb_addr;    // bit 15 set marks an out-of-range access
  logic        ramb_rd;      // single-cycle read request pulse
  logic        ramb_wr;      // single-cycle write request pulse
  logic [7:0]  ramb_dout;    // write data from the requester
  logic [7:0]  ramb_din;     // read data, held until the next read completes
  logic        ramb_rd_ack;  // one-cycle read-complete pulse
  logic        ramb_wr_ack;  // one-cycle write-complete pulse

  modport master (
    output ramb_addr, ramb_rd, ramb_wr, ramb_dout,
    input  ramb_din, ramb_rd_ack, ramb_wr_ack
  );

  modport slave (
    input  ramb_addr, ramb_rd, ramb_wr, ramb_dout,
    output ramb_din, ramb_rd_ack, ramb_wr_ack
  );
endinterface

// File: rtl/upper_ram_arbiter.sv
// Shares one single-port 32Kx8 upper-RAM macro between the Z80 and the
// AdamNet DMA requester. The CPU owns every enable slot in which it selects
// the RAM; a latched DMA request is serviced in the first free cycle after it.
module upper_ram_arbiter #(
  parameter int         AW       = 15,
  parameter logic [7:0] OOR_DATA = 8'hFF
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          clk_en_10m7_i,
  input  logic [AW-1:0] cpu_a_i,
  input  logic          cpu_ce_n_i,
  input  logic          cpu_we_n_i,
  input  logic [7:0]    cpu_d_i,
  input  logic          cpu_wr_en_i,
  output logic [7:0]    cpu_d_o,
  upper_ram_arbiter_if.slave ramb,
  output logic          dma_busy_o,
  output logic          dma_err_o,
  output logic [AW-1:0] mem_a_o,
  output logic          mem_we_o,
  output logic [7:0]    mem_d_o,
  input  logic [7:0]    mem_q_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PEND    = 2'd1,
    S_RD_DATA = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_cpu_slot;
  logic          w_dma_req;
  logic          w_accept;
  logic          w_dma_grant;
  logic          w_err_set;
  logic          w_mem_we;

  logic [AW-1:0] r_addr;
  logic [7:0]    r_data;
  logic          r_is_wr;
  logic          r_oor;
  logic          r_cpu_rd_pend;
  logic [7:0]    r_cpu_d;
  logic [7:0]    r_din;
  logic          r_rd_ack;
  logic          r_wr_ack;
  logic          r_err;

  assign w_cpu_slot = clk_en_10m7_i & ~cpu_ce_n_i;
  assign w_dma_req  = ramb.ramb_rd | ramb.ramb_wr;
  assign w_accept   = (r_state == S_IDLE) & w_dma_req;
  // A pulse arriving while busy is dropped; rd+wr together is taken as a write.
  assign w_err_set  = (w_dma_req & (r_state != S_IDLE))
                    | (w_accept & ramb.ramb_rd & ramb.ramb_wr);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic: a pending request waits out any CPU slot.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_dma_grant = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dma_req) w_state_nxt = S_PEND;
      end
      S_PEND: begin
        if (!w_cpu_slot) begin
          w_dma_grant = 1'b1;
          w_state_nxt = r_is_wr ? S_IDLE : S_RD_DATA;
        end
      end
      S_RD_DATA: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // RAM port mux: CPU slot first, then the granted DMA access, else parked on the CPU address.
  always_comb begin
    mem_a_o  = cpu_a_i;
    mem_d_o  = cpu_d_i;
    w_mem_we = 1'b0;
    if (w_cpu_slot) begin
      w_mem_we = ~cpu_we_n_i & cpu_wr_en_i;
    end else if (w_dma_grant) begin
      mem_a_o  = r_addr;
      mem_d_o  = r_data;
      w_mem_we = r_is_wr & ~r_oor;
    end
  end

  // The strobe is combinational, so it is gated directly to stay low during reset.
  assign mem_we_o = w_mem_we & reset_n_i;

  // Latch the DMA request when it is accepted in IDLE.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_is_wr <= 1'b0;
      r_oor   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= ramb.ramb_addr[AW-1:0];
      r_data  <= ramb.ramb_dout;
      r_is_wr <= ramb.ramb_wr;
      r_oor   <= ramb.ramb_addr[15];
    end
  end

  // DMA completion: capture read data in RD_DATA, one-cycle acks on leaving PEND/RD_DATA.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_din    <= '0;
      r_rd_ack <= 1'b0;
      r_wr_ack <= 1'b0;
    end else begin
      r_rd_ack <= (r_state == S_RD_DATA);
      r_wr_ack <= w_dma_grant & r_is_wr;
      if (r_state == S_RD_DATA) r_din <= r_oor ? OOR_DATA : mem_q_i;
    end
  end

  // CPU read data: capture RAM output the cycle after a read slot and hold it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cpu_rd_pend <= 1'b0;
      r_cpu_d       <= '0;
    end else begin
      r_cpu_rd_pend <= w_cpu_slot & cpu_we_n_i;
      if (r_cpu_rd_pend) r_cpu_d <= mem_q_i;
    end
  end

  // Sticky error flag for dropped or ambiguous requests.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)     r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign cpu_d_o          = r_cpu_d;
  assign ramb.ramb_din    = r_din;
  assign ramb.ramb_rd_ack = r_rd_ack;
  assign ramb.ramb_wr_ack = r_wr_ack;
  assign dma_busy_o       = (r_state != S_IDLE);
  assign dma_err_o        = r_err;

endmodule

// File: doc/upper_ram_arbiter.md
# upper_ram_arbiter

Shares one single-port 32K×8 upper-RAM macro between the Z80 (upper_ram port of cv_console) and the AdamNet DMA requester (ramb_* port). The CPU owns every 10.7 MHz enable slot in which it asserts chip-enable. AdamNet requests are latched and serviced in the free cycles between those slots. The block replaces the dual-port upper_ram in the emu top level, so only one RAM port is needed.

## Interface
Parameters:
- AW, 15, RAM address width (32 KB).
- OOR_DATA, 8'hFF, read data returned for out-of-range DMA reads.

Ports:
- clk_i  in  1  system clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- clk_en_10m7_i  in  1  CPU slot enable.
- cpu_a_i  in  15  CPU address.
- cpu_ce_n_i  in  1  CPU chip enable, active low.
- cpu_we_n_i  in  1  CPU write enable, active low.
- cpu_d_i  in  8  CPU write data.
- cpu_wr_en_i  in  1  write gate; CPU writes reach RAM only when high.
- cpu_d_o  out  8  CPU read data, registered and held.
- ramb_addr  in  16  DMA address; bit 15 set means out of range.
- ramb_rd  in  1  DMA read request, single-cycle pulse.
- ramb_wr  in  1  DMA write request, single-cycle pulse.
- ramb_dout  in  8  DMA write data.
- ramb_din  out  8  DMA read data, held until the next DMA read completes.
- ramb_rd_ack  out  1  one-cycle read-complete pulse.
- ramb_wr_ack  out  1  one-cycle write-complete pulse.
- dma_busy_o  out  1  a request is latched or in flight.
- dma_err_o  out  1  sticky error flag; cleared only by reset.
- mem_a_o  out  15  RAM address (combinational).
- mem_we_o  out  1  RAM write strobe (combinational).
- mem_d_o  out  8  RAM write data (combinational).
- mem_q_i  in  8  RAM read data; synchronous RAM, valid the cycle after its address.

## Operation
- CPU slot: a cycle with clk_en_10m7_i=1 and cpu_ce_n_i=0.
  - The CPU has absolute priority in a CPU slot.
  - mem_a_o=cpu_a_i, mem_d_o=cpu_d_i.
  - mem_we_o = ~cpu_we_n_i & cpu_wr_en_i.
- CPU read: in the cycle after a CPU read slot, cpu_d_o captures mem_q_i on the clock edge. cpu_d_o holds that value until the next CPU read capture. DMA traffic never changes cpu_d_o.
- DMA latch: a pulse on ramb_rd or ramb_wr while in IDLE latches addr, data and type, and the FSM moves to PEND.
  - ramb_rd and ramb_wr together: the request is taken as a write, and dma_err_o is set.
  - A pulse while not in IDLE is dropped and sets dma_err_o.
- FSM states:
  - IDLE → PEND when a request is latched.
  - PEND, CPU slot this cycle → stay in PEND.
  - PEND, write, no CPU slot → drive RAM, then IDLE. ramb_wr_ack=1 next cycle.
  - PEND, read, no CPU slot → drive RAM address, then RD_DATA.
  - RD_DATA → IDLE. ramb_din <= mem_q_i, and ramb_rd_ack=1 next cycle. A CPU slot in RD_DATA is served normally, because the DMA capture uses the previous cycle's mem_q_i.
- Out-of-range DMA (ramb_addr[15]=1):
  - Same state path and timing as an in-range request, but mem_we_o stays low.
  - A read returns OOR_DATA.
  - dma_err_o is not set.
- When neither the CPU nor DMA is granted: mem_we_o=0, and mem_a_o holds cpu_a_i.
- dma_busy_o = (state != IDLE).

## Timing
- Reset values:
  - cpu_d_o=0, ramb_din=0, both acks=0.
  - dma_busy_o=0, dma_err_o=0, FSM=IDLE.
  - mem_we_o=0 while reset is asserted.
- Reset mid-operation: the latched request is discarded and no ack is issued.
- CPU read latency: data appears on cpu_d_o 2 cycles after the slot, which is the next CPU slot at 50% enable duty.
- DMA, no contention, pulse at cycle t:
  - grant at t+1;
  - ramb_wr_ack at t+2;
  - ramb_rd_ack plus data at t+3.
- Each CPU slot that occurs in PEND adds 1 cycle of latency.
- With clk_en_10m7_i at ≤50% duty, the worst case is wr_ack by t+3 and rd_ack by t+4.
- A new request is accepted in the same cycle its predecessor's ack is high, because the FSM is already in IDLE.
- Acks are exactly one cycle wide and never overlap each other.

## Test plan
- CPU-only access:
  - Write 0x5A to 0x1234 in a CPU slot, then read it in the next slot.
  - Required: mem_we_o high for exactly 1 cycle; cpu_d_o=0x5A 2 cycles after the read slot.
- Idle DMA write/read:
  - Pulse ramb_wr to 0x0100 with 0xC3 at t, then ramb_rd to 0x0100.
  - Required: wr_ack at t+2; rd_ack 3 cycles after the read pulse with ramb_din=0xC3.
- Contention:
  - CPU reads 0x0000 every slot at 50% enable; pulse a DMA read of 0x7FFF (preloaded with 0x11).
  - Required: no CPU slot is ever stolen; cpu_d_o stays at the 0x0000 contents; rd_ack within 4 cycles with 0x11.
- Out of range:
  - DMA write to 0x8000 with 0x77, then DMA read of 0x8000.
  - Required: no mem_we_o pulse; RAM unchanged; read returns 0xFF; dma_err_o stays 0.
- Overrun and simultaneous requests:
  - Pulse ramb_rd while in PEND. Required: the pulse is dropped, dma_err_o=1, and only one ack is produced.
  - Separately, pulse ramb_rd and ramb_wr together. Required: a write is performed and dma_err_o=1.
- Async reset in RD_DATA:
  - Assert reset_n_i=0 mid-cycle.
  - Required: outputs reach reset values immediately; no rd_ack appears after release.
